// File: rtl/ddr3_command_responder.sv
// Command-level DDR3 device model: decodes the controller's command bus, tracks open rows per
// bank, stores BL8 write bursts in a local array and replays read bursts after CAS latency.
// One data beat per clk; dq is split into dq_in/dq_out.
module ddr3_command_responder #(
  parameter int ADDRESS_BITWIDTH      = 14,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int DQ_BITWIDTH           = 16,
  parameter int DM_BITWIDTH           = 2,
  parameter int MEM_ADDR_BITS         = 8,
  parameter int CAS_LATENCY           = 5,
  parameter int CAS_WRITE_LATENCY     = 5,
  parameter int BURST_LENGTH          = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ck_en,
  input  logic                             cs_n,
  input  logic                             ras_n,
  input  logic                             cas_n,
  input  logic                             we_n,
  input  logic [BANK_ADDRESS_BITWIDTH-1:0] bank_address,
  input  logic [ADDRESS_BITWIDTH-1:0]      address,
  input  logic [DM_BITWIDTH-1:0]           dm,
  input  logic [DQ_BITWIDTH-1:0]           dq_in,
  output logic [DQ_BITWIDTH-1:0]           dq_out,
  output logic                             dq_oe,
  output logic                             dqs_oe,
  output logic                             init_done,
  output logic [7:0]                       active_bank_mask,
  output logic [15:0]                      refresh_count,
  output logic                             protocol_error
);

  localparam int BeatBits = $clog2(BURST_LENGTH);
  localparam int MemDepth = 1 << MEM_ADDR_BITS;
  localparam int AddrBits = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH + 10;

  typedef enum logic [2:0] {
    CmdMrs   = 3'b000,
    CmdRef   = 3'b001,
    CmdPre   = 3'b010,
    CmdAct   = 3'b011,
    CmdWrite = 3'b100,
    CmdRead  = 3'b101,
    CmdZqcl  = 3'b110,
    CmdNop   = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrWait,
    StRdWait,
    StWrBurst,
    StRdBurst
  } state_e;

  state_e                             state;
  logic [7:0]                         wait_cnt;
  logic [BeatBits-1:0]                beat;
  logic [BANK_ADDRESS_BITWIDTH-1:0]   burst_bank;
  logic [ADDRESS_BITWIDTH-1:0]        burst_row;
  logic [9:0]                         burst_col;
  logic                               burst_ap;
  logic                               mr0_seen;
  logic [ADDRESS_BITWIDTH-1:0]        open_row [8];
  logic [DQ_BITWIDTH-1:0]             mem [MemDepth];

  cmd_e                               cmd;
  logic                               cmd_valid;
  logic                               in_burst;
  logic                               final_beat;
  logic                               engine_free;
  logic [AddrBits-1:0]                beat_addr;
  logic [MEM_ADDR_BITS-1:0]           beat_index;

  // Command decode, engine status and the array index of the current beat
  always_comb begin
    cmd         = cmd_e'({ras_n, cas_n, we_n});
    cmd_valid   = ck_en && !cs_n;
    in_burst    = (state == StWrBurst) || (state == StRdBurst);
    final_beat  = in_burst && (beat == BeatBits'(BURST_LENGTH - 1));
    engine_free = (state == StIdle) || final_beat;
    // Column wraps inside its aligned 8-beat block
    beat_addr   = {burst_bank, burst_row, burst_col[9:3], burst_col[2:0] + beat};
    beat_index  = MEM_ADDR_BITS'(beat_addr);
  end

  // Byte-masked capture of write beats; a reset edge aborts the burst without writing
  always_ff @(posedge clk) begin
    if (!reset && state == StWrBurst) begin
      for (int b = 0; b < DM_BITWIDTH; b++) begin
        if (!dm[b]) mem[beat_index][b*8 +: 8] <= dq_in[b*8 +: 8];
      end
    end
  end

  // Engine FSM, bank/refresh/init bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= StIdle;
      wait_cnt         <= '0;
      beat             <= '0;
      burst_bank       <= '0;
      burst_row        <= '0;
      burst_col        <= '0;
      burst_ap         <= 1'b0;
      mr0_seen         <= 1'b0;
      init_done        <= 1'b0;
      active_bank_mask <= '0;
      refresh_count    <= '0;
      protocol_error   <= 1'b0;
      dq_out           <= '0;
      dq_oe            <= 1'b0;
      dqs_oe           <= 1'b0;
    end else begin
      protocol_error <= 1'b0;
      dq_out         <= '0;
      dq_oe          <= 1'b0;
      dqs_oe         <= 1'b0;

      unique case (state)
        StIdle: ;
        StWrWait, StRdWait: begin
          if (wait_cnt == 8'd0) begin
            state  <= (state == StRdWait) ? StRdBurst : StWrBurst;
            beat   <= '0;
            // Read preamble: strobe enabled one cycle ahead of the first beat
            dqs_oe <= (state == StRdWait);
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        StWrBurst, StRdBurst: begin
          if (state == StRdBurst) begin
            dq_out <= mem[beat_index];
            dq_oe  <= 1'b1;
            dqs_oe <= 1'b1;
          end
          beat <= beat + 1'b1;
          if (final_beat) begin
            state <= StIdle;
            if (burst_ap) active_bank_mask[burst_bank] <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase

      // Later assignments here override the engine's own next state (command chaining)
      if (cmd_valid) begin
        unique case (cmd)
          CmdMrs: if (bank_address == '0) mr0_seen <= 1'b1;
          CmdZqcl: if (mr0_seen) init_done <= 1'b1;
          CmdAct: begin
            if (!init_done || active_bank_mask[bank_address]) begin
              protocol_error <= 1'b1;
            end else begin
              active_bank_mask[bank_address] <= 1'b1;
              open_row[bank_address]         <= address;
            end
          end
          CmdPre: begin
            if (!init_done) protocol_error <= 1'b1;
            else if (address[10]) active_bank_mask <= '0;
            else active_bank_mask[bank_address] <= 1'b0;
          end
          CmdRef: begin
            if (!init_done || (active_bank_mask != '0)) protocol_error <= 1'b1;
            else if (refresh_count != 16'hFFFF) refresh_count <= refresh_count + 16'd1;
          end
          CmdWrite, CmdRead: begin
            if (!init_done || !active_bank_mask[bank_address] || !engine_free) begin
              protocol_error <= 1'b1;
            end else begin
              state      <= (cmd == CmdRead) ? StRdWait : StWrWait;
              wait_cnt   <= (cmd == CmdRead) ? 8'(CAS_LATENCY - 2) : 8'(CAS_WRITE_LATENCY - 2);
              burst_bank <= bank_address;
              burst_row  <= open_row[bank_address];
              burst_col  <= address[9:0];
              burst_ap   <= address[10];
            end
          end
          CmdNop: ;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr3_command_responder.sv
// Directed bench for ddr3_command_responder: a cycle-indexed behavioural model predicts every
// output each cycle; literal checks at key points pin the model to hand-computed values.
module tb_ddr3_command_responder;

  localparam int CL   = 5;
  localparam int CWL  = 5;
  localparam int MAXC = 4096;

  localparam logic [2:0] CMRS = 3'b000, CREF = 3'b001, CPRE = 3'b010, CACT = 3'b011;
  localparam logic [2:0] CWR  = 3'b100, CRD  = 3'b101, CZQ  = 3'b110, CNOP = 3'b111;

  logic        clk = 1'b0;
  logic        reset, ck_en, cs_n, ras_n, cas_n, we_n;
  logic [2:0]  bank_address;
  logic [13:0] address;
  logic [1:0]  dm;
  logic [15:0] dq_in, dq_out;
  logic        dq_oe, dqs_oe, init_done, protocol_error;
  logic [7:0]  active_bank_mask;
  logic [15:0] refresh_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  ddr3_command_responder dut (
    .clk(clk), .reset(reset), .ck_en(ck_en), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .bank_address(bank_address), .address(address), .dm(dm), .dq_in(dq_in),
    .dq_out(dq_out), .dq_oe(dq_oe), .dqs_oe(dqs_oe), .init_done(init_done),
    .active_bank_mask(active_bank_mask), .refresh_count(refresh_count),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model, indexed by clock edge number ----------------
  logic        m_init, m_mr0;
  logic [7:0]  m_open;
  logic [15:0] m_ref;
  logic [13:0] m_row [8];
  logic [15:0] m_mem [256];
  int          last_final;
  bit          wr_v [MAXC];
  int          wr_a [MAXC];
  bit          rd_v [MAXC];
  int          rd_a [MAXC];
  bit          ap_v [MAXC];
  int          ap_b [MAXC];
  bit          e_oe [MAXC];
  bit          e_dqs[MAXC];
  bit          e_err[MAXC];
  logic [15:0] e_dq [MAXC];

  function automatic int beat_index(int bank, int row, int col, int i);
    int cb;
    cb = (col & ~7) | ((col + i) & 7);
    return (bank * (1 << 24) + row * (1 << 10) + cb) % 256;
  endfunction

  task automatic model_step(input int e);
    int lat, k, ba;
    logic [2:0] c;
    if (reset) begin
      m_init = 0; m_mr0 = 0; m_open = 0; m_ref = 0; last_final = 0;
      for (int j = e; j < e + 64 && j < MAXC; j++) begin
        wr_v[j] = 0; rd_v[j] = 0; ap_v[j] = 0;
        e_oe[j] = 0; e_dqs[j] = 0; e_err[j] = 0; e_dq[j] = 16'h0;
      end
    end else begin
      if (wr_v[e])
        for (int j = 0; j < 2; j++)
          if (!dm[j]) m_mem[wr_a[e]][j*8 +: 8] = dq_in[j*8 +: 8];
      if (rd_v[e]) e_dq[e] = m_mem[rd_a[e]];
      if (ck_en && !cs_n) begin
        c  = {ras_n, cas_n, we_n};
        ba = int'(bank_address);
        case (c)
          CMRS: if (bank_address == 3'd0) m_mr0 = 1;
          CZQ:  if (m_mr0) m_init = 1;
          CACT: if (!m_init || m_open[ba]) e_err[e] = 1;
                else begin m_open[ba] = 1; m_row[ba] = address; end
          CPRE: if (!m_init) e_err[e] = 1;
                else if (address[10]) m_open = 0;
                else m_open[ba] = 0;
          CREF: if (!m_init || m_open != 0) e_err[e] = 1;
                else if (m_ref != 16'hFFFF) m_ref = m_ref + 1;
          CWR, CRD: begin
            if (!m_init || !m_open[ba] || e < last_final) e_err[e] = 1;
            else begin
              lat = (c == CRD) ? CL : CWL;
              for (int i = 0; i < 8; i++) begin
                k = e + lat + i;
                if (c == CRD) begin
                  rd_v[k] = 1; e_oe[k] = 1; e_dqs[k] = 1;
                  rd_a[k] = beat_index(ba, int'(m_row[ba]), int'(address[9:0]), i);
                end else begin
                  wr_v[k] = 1;
                  wr_a[k] = beat_index(ba, int'(m_row[ba]), int'(address[9:0]), i);
                end
              end
              if (c == CRD) e_dqs[e + lat - 1] = 1;
              last_final = e + lat + 7;
              if (address[10]) begin ap_v[last_final] = 1; ap_b[last_final] = ba; end
            end
          end
          default: ;
        endcase
      end
      // Auto-precharge takes effect after the final beat's edge
      if (ap_v[e]) m_open[ap_b[e]] = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step(cyc);
  end

  // Compare every output against the model each cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    if (cyc > 0 && cyc < MAXC) begin
      check("dq_oe", dq_oe, e_oe[cyc]);
      check("dqs_oe", dqs_oe, e_dqs[cyc]);
      check("dq_out", dq_out, e_oe[cyc] ? e_dq[cyc] : 16'h0);
      check("protocol_error", protocol_error, e_err[cyc]);
      check("init_done", init_done, m_init);
      check("active_bank_mask", active_bank_mask, m_open);
      check("refresh_count", refresh_count, m_ref);
    end
  end

  // ---------------- stimulus ----------------
  logic        got_oe [14];
  logic        got_dqs[14];
  logic [15:0] got_dq [14];
  logic [7:0]  mask_pre;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input logic [2:0] c, input logic [2:0] ba, input logic [13:0] a);
    cs_n = 1'b0; {ras_n, cas_n, we_n} = c; bank_address = ba; address = a;
    tick(1);
    {ras_n, cas_n, we_n} = CNOP;
  endtask

  task automatic read_collect(input logic [2:0] ba, input logic [13:0] a);
    issue(CRD, ba, a);
    for (int k = 0; k < 14; k++) begin
      if (k > 0) tick(1);
      got_oe[k] = dq_oe; got_dqs[k] = dqs_oe; got_dq[k] = dq_out;
    end
  endtask

  task automatic write_burst(input logic [2:0] ba, input logic [13:0] a, input logic [15:0] base,
                             input int special, input logic [15:0] sdata, input logic [1:0] sdm,
                             input logic [1:0] odm, output logic [7:0] mpre);
    issue(CWR, ba, a);
    tick(CWL - 1);
    mpre = 8'h0;
    for (int i = 0; i < 8; i++) begin
      dq_in = (i == special) ? sdata : base + 16'(i);
      dm    = (i == special) ? sdm : odm;
      if (i == 7) mpre = active_bank_mask;
      tick(1);
    end
    dm = 2'b00; dq_in = 16'h0;
  endtask

  initial begin
    reset = 1'b1; ck_en = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = CNOP;
    bank_address = 3'd0; address = 14'd0; dm = 2'b00; dq_in = 16'h0;
    tick(3);
    check("reset_init_done", init_done, 1'b0);
    check("reset_mask", active_bank_mask, 8'h00);
    reset = 1'b0;
    tick(1);

    // ACT before init: error pulse, nothing opened
    issue(CACT, 3'd2, 14'd5);
    check("act_before_init_err", protocol_error, 1'b1);
    check("act_before_init_mask", active_bank_mask, 8'h00);
    issue(CMRS, 3'd0, 14'd0);
    check("mrs_no_init", init_done, 1'b0);
    issue(CZQ, 3'd0, 14'd0);
    check("zqcl_init_done", init_done, 1'b1);

    issue(CACT, 3'd2, 14'd5);
    check("act_bank2_mask", active_bank_mask, 8'h04);

    write_burst(3'd2, 14'd0, 16'h0000, -1, 16'h0, 2'b00, 2'b00, mask_pre);
    tick(1);

    read_collect(3'd2, 14'd0);
    check("rd0_dqs_pre_low", got_dqs[3], 1'b0);
    check("rd0_dqs_preamble", got_dqs[4], 1'b1);
    check("rd0_oe_before", got_oe[4], 1'b0);
    check("rd0_dq_idle_zero", got_dq[4], 16'h0);
    check("rd0_oe_first", got_oe[5], 1'b1);
    check("rd0_beat0", got_dq[5], 16'h0000);
    check("rd0_beat7", got_dq[12], 16'h0007);
    check("rd0_oe_after", got_oe[13], 1'b0);

    read_collect(3'd2, 14'd3);
    check("rd3_beat0", got_dq[5], 16'h0003);
    check("rd3_beat4", got_dq[9], 16'h0007);
    check("rd3_beat5_wrap", got_dq[10], 16'h0000);
    check("rd3_beat7", got_dq[12], 16'h0002);

    write_burst(3'd2, 14'd0, 16'hFF00, 1, 16'hABCD, 2'b10, 2'b11, mask_pre);
    tick(1);
    read_collect(3'd2, 14'd0);
    check("dm_beat0_kept", got_dq[5], 16'h0000);
    check("dm_beat1_lowbyte", got_dq[6], 16'h00CD);
    check("dm_beat2_kept", got_dq[7], 16'h0002);

    // Illegal commands
    issue(CRD, 3'd3, 14'd0);
    check("read_closed_err", protocol_error, 1'b1);
    issue(CACT, 3'd2, 14'd9);
    check("act_open_err", protocol_error, 1'b1);
    issue(CREF, 3'd0, 14'd0);
    check("ref_open_err", protocol_error, 1'b1);
    issue(CRD, 3'd2, 14'd0);
    tick(CL + 1);
    issue(CRD, 3'd2, 14'd0);
    check("read_busy_err", protocol_error, 1'b1);
    tick(6);
    check("err_refresh_unchanged", refresh_count, 16'd0);
    check("err_mask_unchanged", active_bank_mask, 8'h04);

    // Auto-precharge write
    write_burst(3'd2, 14'h408, 16'h1000, -1, 16'h0, 2'b00, 2'b00, mask_pre);
    check("ap_open_before_last", mask_pre, 8'h04);
    check("ap_closed_after_last", active_bank_mask, 8'h00);

    issue(CACT, 3'd1, 14'd3);
    issue(CACT, 3'd4, 14'd7);
    check("two_banks_open", active_bank_mask, 8'h12);
    issue(CPRE, 3'd5, 14'd0);
    check("pre_closed_bank_ok", protocol_error, 1'b0);
    issue(CPRE, 3'd0, 14'h400);
    check("pre_all", active_bank_mask, 8'h00);
    repeat (3) issue(CREF, 3'd0, 14'd0);
    check("refresh_three", refresh_count, 16'd3);

    // CKE low: command ignored silently
    ck_en = 1'b0;
    issue(CACT, 3'd6, 14'd1);
    check("cke_low_no_err", protocol_error, 1'b0);
    check("cke_low_no_act", active_bank_mask, 8'h00);
    ck_en = 1'b1;

    // Reset in the middle of a read burst
    issue(CACT, 3'd2, 14'd5);
    issue(CRD, 3'd2, 14'd0);
    tick(CL + 1);
    check("mid_read_oe", dq_oe, 1'b1);
    reset = 1'b1;
    tick(1);
    check("reset_mid_oe", dq_oe, 1'b0);
    check("reset_mid_dqs", dqs_oe, 1'b0);
    check("reset_mid_mask", active_bank_mask, 8'h00);
    check("reset_mid_refresh", refresh_count, 16'd0);
    reset = 1'b0;
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr3_command_responder.md
Name: ddr3_command_responder

Overview:
- Synthesizable, command-level DDR3 device-side responder.
- Decodes the command bus driven by ddr3_memory_controller, tracks per-bank open rows, stores write bursts in an internal array and returns read bursts after CAS latency.
- Used in place of external RAM for FPGA loopback and formal runs. Abstraction: one data beat per clk cycle, split dq_in/dq_out instead of inout.

Parameters:
- ADDRESS_BITWIDTH, 14, row/column address width.
- BANK_ADDRESS_BITWIDTH, 3, bank address width (8 banks).
- DQ_BITWIDTH, 16, data beat width.
- DM_BITWIDTH, 2, byte mask width (DQ_BITWIDTH/8).
- MEM_ADDR_BITS, 8, log2 of internal storage depth in beats.
- CAS_LATENCY, 5, read command to first read beat, in cycles (>=2).
- CAS_WRITE_LATENCY, 5, write command to first write beat, in cycles (>=2).
- BURST_LENGTH, 8, beats per READ/WRITE (fixed BL8).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ck_en  in  1  CKE; low = commands ignored
- cs_n  in  1  chip select
- ras_n  in  1  RAS#
- cas_n  in  1  CAS#
- we_n  in  1  WE#
- bank_address  in  BANK_ADDRESS_BITWIDTH  BA
- address  in  ADDRESS_BITWIDTH  A; A10 = auto-precharge / precharge-all
- dm  in  DM_BITWIDTH  write byte mask, 1 = byte not written
- dq_in  in  DQ_BITWIDTH  write data beat
- dq_out  out  DQ_BITWIDTH  read data beat
- dq_oe  out  1  dq_out valid/driven
- dqs_oe  out  1  strobe drive enable (includes 1-cycle preamble)
- init_done  out  1  initialization complete
- active_bank_mask  out  8  bit b = bank b has an open row
- refresh_count  out  16  accepted REF commands, saturating
- protocol_error  out  1  one-cycle pulse on illegal command

Behaviour:
- Reset: all outputs 0, all banks closed, engine IDLE, mr0_seen=0. Storage array contents not reset. Reset mid-burst aborts the burst; dq_oe/dqs_oe low the cycle after reset is sampled.
- Commands are sampled on posedge clk only when ck_en=1 and cs_n=0. {ras_n,cas_n,we_n}: 000 MRS, 001 REF, 010 PRE, 011 ACT, 100 WRITE, 101 READ, 110 ZQCL, 111 NOP.
- MRS: BA=0 sets mr0_seen. ZQCL with mr0_seen=1 sets init_done, which stays high until reset. ZQCL with mr0_seen=0 is ignored, no error.
- Before init_done, ACT/READ/WRITE/REF/PRE each pulse protocol_error and are ignored.
- ACT: opens bank BA, latches row=address. ACT to an already-open bank -> error, ignored.
- PRE: A10=1 closes all banks; A10=0 closes bank BA. PRE to a closed bank is legal (no-op).
- REF: all banks closed -> refresh_count+1, saturating at 16'hFFFF. Any bank open -> error, not counted.
- READ/WRITE: target bank closed -> error, ignored. Engine not IDLE and not in its final beat -> error, ignored.
- On acceptance, latch bank, open row, column = address[9:0], and A10 (auto-precharge).
- Beat address i = {col[9:3], (col[2:0]+i) mod 8}, i.e. wraps within the aligned 8-beat block.
- Storage index = low MEM_ADDR_BITS of {bank, row, column-of-beat}.
- Auto-precharge: the bank closes after the final beat.
- Explicit PRE during a burst closes the bank immediately. The burst completes on its latched index.
- Engine FSM: IDLE -> WR_WAIT or RD_WAIT (count latency-1 cycles) -> WR_BURST or RD_BURST (BURST_LENGTH cycles) -> IDLE. A new command accepted in the final beat chains directly into its WAIT state.
- Write timing (command sampled at cycle T):
  - beats captured at T+CWL .. T+CWL+7;
  - each byte written only if its dm bit is 0;
  - dqs_oe=0 (host drives strobe).
- Read timing (command sampled at cycle T):
  - dq_out/dq_oe registered, valid T+CL .. T+CL+7;
  - dqs_oe high T+CL-1 .. T+CL+7;
  - dq_out = 0 whenever dq_oe=0.
- Read of a beat written in the same cycle returns the old value (read-before-write array).
- ck_en=0: commands ignored, no error; an in-flight burst continues.

Test Plan:
- Reset, MRS BA=0, ZQCL -> init_done=1 the cycle after ZQCL; ACT before MRS -> protocol_error pulse, active_bank_mask=0.
- ACT bank2 row 5, WRITE col 0, dq_in=0x0000..0x0007, dm=0; READ col 0 at T -> dq_oe at T+5..T+12, dq_out=0x0000..0x0007, dqs_oe from T+4.
- READ col 3 of the same block -> beats 0x0003,0x0004..0x0007,0x0000,0x0001,0x0002 (wrap).
- WRITE with dm=2'b10 on beat 1 with data 0xABCD over old 0x0001 -> readback beat 1 = 0x00CD.
- READ to closed bank, ACT to open bank, REF with bank open, second READ issued at burst beat 3 -> four protocol_error pulses, no state change, refresh_count unchanged.
- WRITE with A10=1 -> bank bit clears after beat 7. PRE A10=1 then 3 REF -> refresh_count=3. Reset asserted mid-read -> dq_oe=0 the next cycle, active_bank_mask=0.
